// File: rtl/pipeline_control.sv
// Stall/flush controller for the 5-stage pipeline: PC enable plus load-enable/bubble per stage register.
// Optional stall performance counter enabled by `define PIPELINE_CONTROL_STALL_CNT_EN.
//   state    | meaning
//   FLUSH    | one cycle after reset, all stage registers load NOPs
//   RUN      | normal issue; resolves memory wait, branch squash, load-use, halt
//   MEM_WAIT | memory access outstanding, front of pipe frozen
//   HALTED   | everything frozen until resume
module pipeline_control #(
    parameter int MEM_TIMEOUT = 255,
    parameter int WAIT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        halt_req,
    input  logic        resume,
    output logic        pc_en,
    output logic [3:0]  reg_en,
    output logic [3:0]  reg_bubble,
    output logic [1:0]  state,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_FLUSH    = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] CNT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] CNT_MAX   = '1;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              mem_stall;
    logic              load_use;

    always_comb begin
        mem_stall = mem_req && !mem_ready;
        load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    end

    always_comb begin
        pc_en         = 1'b1;
        reg_en        = 4'b1111;
        reg_bubble    = 4'b0000;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;

        unique case (state_q)
            ST_FLUSH: begin
                pc_en      = 1'b0;
                reg_bubble = 4'b1111;
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
            ST_RUN: begin
                if (mem_stall) begin
                    pc_en      = 1'b0;
                    reg_en     = 4'b1000;
                    reg_bubble = 4'b1000;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = CNT_ONE;
                end else if (ex_branch_taken) begin
                    // Squash wins over load-use: the dependent instruction is being discarded anyway.
                    reg_bubble = 4'b0011;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    reg_en     = 4'b1110;
                    reg_bubble = 4'b0010;
                end else if (halt_req) begin
                    state_d = ST_HALTED;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    pc_en      = 1'b0;
                    reg_en     = 4'b1000;
                    reg_bubble = 4'b1000;
                    if ((MEM_TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_V)) begin
                        mem_timeout_d = 1'b1;
                        state_d       = ST_HALTED;
                        wait_cnt_d    = '0;
                    end else if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + CNT_ONE;
                    end
                end
            end
            ST_HALTED: begin
                pc_en  = 1'b0;
                reg_en = 4'b0000;
                if (resume) begin
                    state_d       = ST_RUN;
                    mem_timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_FLUSH;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign state       = state_q;
    assign mem_timeout = mem_timeout_q;

`ifdef PIPELINE_CONTROL_STALL_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !pc_en &&
            (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: each step drives one cycle of inputs and
// queues the expected {pc_en, reg_en, reg_bubble, state, mem_timeout} for that cycle.
module tb_pipeline_control;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        halt_req;
    logic        resume;
    logic        pc_en;
    logic [3:0]  reg_en;
    logic [3:0]  reg_bubble;
    logic [1:0]  state;
    logic        mem_timeout;
    logic [31:0] stall_cycles;

    pipeline_control #(.MEM_TIMEOUT(4), .WAIT_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .halt_req        (halt_req),
        .resume          (resume),
        .pc_en           (pc_en),
        .reg_en          (reg_en),
        .reg_bubble      (reg_bubble),
        .state           (state),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mrd;
        logic [4:0] rd;
        logic       br;
        logic       mreq;
        logic       mrdy;
        logic       hreq;
        logic       res;
    } stim_t;

    logic [11:0] sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          exp_stalls = 0;
    logic [11:0] exp_v;
    logic [11:0] obs;
    logic [31:0] exp_sc;

    function automatic stim_t st(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                                 input logic mr, input logic [4:0] rd, input logic br,
                                 input logic mq, input logic my, input logic hq, input logic rs_);
        stim_t s;
        s.rs = rs; s.rt = rt; s.uses_rt = ur; s.mrd = mr; s.rd = rd;
        s.br = br; s.mreq = mq; s.mrdy = my; s.hreq = hq; s.res = rs_;
        return s;
    endfunction

    function automatic logic [11:0] mk(input logic pc, input logic [3:0] en, input logic [3:0] bub,
                                       input logic [1:0] stt, input logic to);
        return {pc, en, bub, stt, to};
    endfunction

    task automatic drive(input stim_t s);
        id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.uses_rt; ex_mem_read = s.mrd; ex_rd = s.rd;
        ex_branch_taken = s.br; mem_req = s.mreq; mem_ready = s.mrdy; halt_req = s.hreq; resume = s.res;
    endtask

    localparam stim_t IDLE = '0;

    function automatic logic [11:0] e_run();   return mk(1'b1, 4'b1111, 4'b0000, 2'd1, 1'b0); endfunction
    function automatic logic [11:0] e_flush(); return mk(1'b0, 4'b1111, 4'b1111, 2'd0, 1'b0); endfunction
    function automatic logic [11:0] e_lu();    return mk(1'b0, 4'b1110, 4'b0010, 2'd1, 1'b0); endfunction
    function automatic logic [11:0] e_br();    return mk(1'b1, 4'b1111, 4'b0011, 2'd1, 1'b0); endfunction
    function automatic logic [11:0] e_mw(input logic [1:0] stt); return mk(1'b0, 4'b1000, 4'b1000, stt, 1'b0); endfunction
    function automatic logic [11:0] e_halt(input logic to);      return mk(1'b0, 4'b0000, 4'b0000, 2'd3, to); endfunction

    task automatic test_reset();
        stim_t       s[$];
        logic [11:0] e[$];
        drive(IDLE);
        rst = 1'b0;
        #1;
        sb.push_back(e_flush());
        exp_v = sb.pop_front();
        obs = {pc_en, reg_en, reg_bubble, state, mem_timeout};
        vectors++;
        if (obs !== exp_v || stall_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_hold: got %h/%0d, expected %h/0", obs, stall_cycles, exp_v);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        s.push_back(IDLE); e.push_back(e_flush());
        s.push_back(IDLE); e.push_back(e_run());
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]); sb.push_back(e[i]);
            @(negedge clk);
            exp_v = sb.pop_front();
            obs = {pc_en, reg_en, reg_bubble, state, mem_timeout};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_release step %0d: got %h, expected %h", i, obs, exp_v);
            end
            if (!exp_v[11] && (exp_v[2:1] == 2'd1 || exp_v[2:1] == 2'd2)) exp_stalls++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t       s[$];
        logic [11:0] e[$];
        s.push_back(st(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); e.push_back(e_lu());
        s.push_back(IDLE);                                                          e.push_back(e_run());
        s.push_back(st(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); e.push_back(e_lu());
        s.push_back(st(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); e.push_back(e_run());
        s.push_back(st(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); e.push_back(e_run());
        s.push_back(st(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); e.push_back(e_run());
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]); sb.push_back(e[i]);
            @(negedge clk);
            exp_v = sb.pop_front();
            obs = {pc_en, reg_en, reg_bubble, state, mem_timeout};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL load_use step %0d: got %h, expected %h", i, obs, exp_v);
            end
            if (!exp_v[11] && (exp_v[2:1] == 2'd1 || exp_v[2:1] == 2'd2)) exp_stalls++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_hazard();
        stim_t       s[$];
        logic [11:0] e[$];
        s.push_back(st(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); e.push_back(e_br());
        s.push_back(st(5'd1, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); e.push_back(e_br());
        s.push_back(IDLE);                                                          e.push_back(e_run());
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]); sb.push_back(e[i]);
            @(negedge clk);
            exp_v = sb.pop_front();
            obs = {pc_en, reg_en, reg_bubble, state, mem_timeout};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL branch_hazard step %0d: got %h, expected %h", i, obs, exp_v);
            end
            if (!exp_v[11] && (exp_v[2:1] == 2'd1 || exp_v[2:1] == 2'd2)) exp_stalls++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t       s[$];
        logic [11:0] e[$];
        s.push_back(st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)); e.push_back(e_run());
        s.push_back(st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)); e.push_back(e_mw(2'd1));
        s.push_back(st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0)); e.push_back(e_mw(2'd2));
        s.push_back(st(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)); e.push_back(e_mw(2'd2));
        s.push_back(st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)); e.push_back(mk(1'b1, 4'b1111, 4'b0000, 2'd2, 1'b0));
        s.push_back(IDLE);                                                          e.push_back(e_run());
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]); sb.push_back(e[i]);
            @(negedge clk);
            exp_v = sb.pop_front();
            obs = {pc_en, reg_en, reg_bubble, state, mem_timeout};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL mem_wait step %0d: got %h, expected %h", i, obs, exp_v);
            end
            if (!exp_v[11] && (exp_v[2:1] == 2'd1 || exp_v[2:1] == 2'd2)) exp_stalls++;
            @(posedge clk); #1;
        end
`ifdef PIPELINE_CONTROL_STALL_CNT_EN
        exp_sc = 32'(exp_stalls);
`else
        exp_sc = 32'd0;
`endif
        vectors++;
        if (stall_cycles !== exp_sc) begin
            miscompares++;
            $display("FAIL mem_wait_stall_cycles: got %0d, expected %0d", stall_cycles, exp_sc);
        end
    endtask

    task automatic test_timeout();
        stim_t       s[$];
        logic [11:0] e[$];
        stim_t       wt;
        wt = st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        s.push_back(wt); e.push_back(e_mw(2'd1));
        for (int k = 0; k < 4; k++) begin
            s.push_back(wt); e.push_back(e_mw(2'd2));
        end
        s.push_back(st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)); e.push_back(e_halt(1'b1));
        s.push_back(st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)); e.push_back(e_halt(1'b1));
        s.push_back(IDLE);                                                          e.push_back(e_run());
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]); sb.push_back(e[i]);
            @(negedge clk);
            exp_v = sb.pop_front();
            obs = {pc_en, reg_en, reg_bubble, state, mem_timeout};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL timeout step %0d: got %h, expected %h", i, obs, exp_v);
            end
            if (!exp_v[11] && (exp_v[2:1] == 2'd1 || exp_v[2:1] == 2'd2)) exp_stalls++;
            @(posedge clk); #1;
        end
`ifdef PIPELINE_CONTROL_STALL_CNT_EN
        exp_sc = 32'(exp_stalls);
`else
        exp_sc = 32'd0;
`endif
        vectors++;
        if (stall_cycles !== exp_sc) begin
            miscompares++;
            $display("FAIL timeout_stall_cycles: got %0d, expected %0d", stall_cycles, exp_sc);
        end
    endtask

    task automatic test_halt_reset();
        stim_t       s[$];
        logic [11:0] e[$];
        stim_t       wt;
        wt = st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        s.push_back(st(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)); e.push_back(e_lu());
        s.push_back(st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)); e.push_back(e_run());
        s.push_back(IDLE);                                                          e.push_back(e_halt(1'b0));
        s.push_back(st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)); e.push_back(e_halt(1'b0));
        s.push_back(st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)); e.push_back(e_halt(1'b0));
        s.push_back(IDLE);                                                          e.push_back(e_run());
        s.push_back(wt);                                                            e.push_back(e_mw(2'd1));
        for (int k = 0; k < 4; k++) begin
            s.push_back(wt); e.push_back(e_mw(2'd2));
        end
        s.push_back(IDLE);                                                          e.push_back(e_halt(1'b1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]); sb.push_back(e[i]);
            @(negedge clk);
            exp_v = sb.pop_front();
            obs = {pc_en, reg_en, reg_bubble, state, mem_timeout};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL halt step %0d: got %h, expected %h", i, obs, exp_v);
            end
            if (!exp_v[11] && (exp_v[2:1] == 2'd1 || exp_v[2:1] == 2'd2)) exp_stalls++;
            @(posedge clk); #1;
        end
        // Still HALTED with the timeout flag set; reset lands between clock edges.
        #1 rst = 1'b0;
        sb.push_back(e_flush());
        exp_stalls = 0;
        #1;
        exp_v = sb.pop_front();
        obs = {pc_en, reg_en, reg_bubble, state, mem_timeout};
        vectors++;
        if (obs !== exp_v || stall_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL async_reset_mid_halt: got %h/%0d, expected %h/0", obs, stall_cycles, exp_v);
        end
        @(posedge clk); #1 rst = 1'b1;
        s.delete(); e.delete();
        s.push_back(IDLE); e.push_back(e_flush());
        s.push_back(IDLE); e.push_back(e_run());
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]); sb.push_back(e[i]);
            @(negedge clk);
            exp_v = sb.pop_front();
            obs = {pc_en, reg_en, reg_bubble, state, mem_timeout};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL post_reset step %0d: got %h, expected %h", i, obs, exp_v);
            end
            if (!exp_v[11] && (exp_v[2:1] == 2'd1 || exp_v[2:1] == 2'd2)) exp_stalls++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_hazard();
        test_mem_wait();
        test_timeout();
        test_halt_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the PC enable and the load-enable and bubble (insert-zero) controls of the four inter-stage pipeline registers.
- Resolves load-use hazards, taken-branch squashes, multi-cycle memory waits (with timeout), and an external halt/resume.

Parameters:
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before a timeout halt; 0 disables the timeout.
- WAIT_W, 8: width of the wait counter; must satisfy 2^WAIT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- id_rs  in  5  source register 1 of the instruction in ID.
- id_rt  in  5  source register 2 of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads id_rt.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  5  destination register of the EX instruction.
- ex_branch_taken  in  1  EX resolved a taken branch/jump.
- mem_req  in  1  MEM stage is performing a memory access.
- mem_ready  in  1  memory access completes this cycle.
- halt_req  in  1  request to halt the pipeline.
- resume  in  1  leave the HALTED state.
- pc_en  out  1  PC load enable.
- reg_en  out  4  load enables; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB.
- reg_bubble  out  4  same bit order; when set, the register loads zero (a NOP) instead of its input.
- state  out  2  FLUSH=0, RUN=1, MEM_WAIT=2, HALTED=3.
- mem_timeout  out  1  sticky timeout flag.
- stall_cycles  out  32  stall performance counter (see Optional Feature).

Behaviour:
Reset and general rules
- rst low (asynchronous): state=FLUSH, wait_cnt=0, mem_timeout=0, stall_cycles=0.
- While state=FLUSH: pc_en=0, reg_en=4'b1111, reg_bubble=4'b1111.
- FLUSH lasts exactly one clk edge after rst deasserts, then goes to RUN.
- pc_en, reg_en and reg_bubble are combinational from the state and current inputs; state, wait_cnt and flags are registered.
- A bubble bit is only meaningful when the matching reg_en bit is 1.
- Reset mid-operation aborts any wait or halt immediately; there is no drain.

RUN: the default is pc_en=1, reg_en=1111, reg_bubble=0000. Conditions are evaluated in the priority order below.
1. Memory wait (mem_req=1, mem_ready=0):
   - pc_en=0, reg_en=1000, reg_bubble=1000: freeze PC through EX/MEM, bubble into MEM/WB.
   - Next state MEM_WAIT; wait_cnt<=1.
2. Taken branch (ex_branch_taken=1):
   - pc_en=1 (the datapath selects the target), reg_bubble=0011 (squash the IF and ID instructions).
   - Any simultaneous load-use hazard is ignored.
3. Load-use hazard:
   - Condition: ex_mem_read=1, ex_rd!=0, and (ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt)).
   - Response: pc_en=0, reg_en=1110, reg_bubble=0010. This is exactly a one-cycle stall.
4. Halt (halt_req=1 and none of 1–3 active):
   - This cycle completes normally; next state HALTED.
- mem_req=1 with mem_ready=1 in the same cycle causes no stall.

MEM_WAIT
- Outputs are the same as rule 1 while mem_ready=0; wait_cnt increments each cycle.
- On mem_ready=1: pc_en=1, reg_en=1111, reg_bubble=0000; next state RUN; wait_cnt<=0.
- If MEM_TIMEOUT!=0, wait_cnt==MEM_TIMEOUT and mem_ready=0: mem_timeout<=1, next state HALTED.
- Branch, hazard and halt inputs are ignored. The frozen ID/EX and EX/MEM registers hold them stable, so they are re-evaluated after release.
- halt_req is not latched while in MEM_WAIT.

HALTED
- pc_en=0, reg_en=0000, reg_bubble=0000.
- resume=1 leads to RUN on the next edge and clears mem_timeout.
- halt_req is ignored in this state.

Optional Feature:
- Macro: PIPELINE_CONTROL_STALL_CNT_EN.
- Defined: stall_cycles increments on every clk where state is RUN or MEM_WAIT and pc_en=0. It saturates at 32'hFFFFFFFF and is cleared only by reset.
- Undefined: stall_cycles is tied to 0 and no counter logic is generated. The port list is identical in both builds.

Test Plan:
- Reset release: rst low, then high.
  - Cycle 0 after release: state=0, reg_bubble=1111, pc_en=0.
  - Next cycle: state=1, pc_en=1, reg_en=1111.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5.
  - Expect pc_en=0, reg_en=1110, reg_bubble=0010 for one cycle.
  - With ex_rd=0, expect no stall.
- Branch plus hazard together: ex_branch_taken=1 with the load-use condition above.
  - Expect pc_en=1, reg_en=1111, reg_bubble=0011.
- Memory wait: mem_req=1, mem_ready low for 3 cycles, then high.
  - Expect 3 cycles of pc_en=0, reg_en=1000, reg_bubble=1000 (state=2).
  - Then release to 1111/0000 and state=1.
  - With the _EN macro defined, stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held.
  - After 4 wait cycles: state=3, mem_timeout=1.
  - Then resume=1 leads to state=1, mem_timeout=0.
- Halt and async reset: halt_req=1 in RUN leads to state=3 with all enables 0.
  - Assert rst mid-halt: immediately state=0 and mem_timeout=0.
